sim_run_ctrl: RTL and testbench
===============================

# sim_run_ctrl

Parametrised run controller for simulation tops: sequences the CPU start pulse after reset and watches NUM_CH register-file write ports for end-of-test codes and unknown data. It enforces a cycle-count timeout and reports pass/fail/timeout with counters. It sits in the sim top beside fpga_top. It replaces hand-written force/delay/$stop sequences and per-test X monitors.

## Interface
- DW, 32, register write data width
- NUM_CH, 1, number of monitored write ports (1..8)
- START_DLY, 2, cycles from reset release to first cpu_start cycle (>=1)
- START_LEN, 1, cpu_start pulse length in cycles (>=1)
- MAX_CYCLES, 500000, RUN-state cycle budget before timeout (>=1)
- CW, 32, cycle counter width
- END_REG, 3, register address carrying the end code
- PASS_VAL, 1, end code meaning pass
- FAIL_VAL, 32'hDEAD_0001, end code meaning fail
- clkin  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mon_wen  in  NUM_CH  per-channel register write enable
- mon_waddr  in  NUM_CH*5  per-channel write address; channel i at [5i+4:5i]
- mon_wdata  in  NUM_CH*DW  per-channel write data; channel i at [DW*i+DW-1:DW*i]
- cpu_start  out  1  start pulse to fpga_top
- running  out  1  high in RUN
- done  out  1  high in DONE, sticky until reset
- pass  out  1  end code was PASS_VAL
- timeout  out  1  budget exhausted
- cycle_cnt  out  CW  RUN cycles elapsed
- x_err_cnt  out  16  unknown-data writes seen, saturating
- x_err_ch  out  NUM_CH  sticky per-channel unknown-write flags

## Operation
- States: WAIT, START, RUN, DONE. Reset enters WAIT with all counters 0.
- WAIT: delay counter increments each cycle. At START_DLY-1, go to START and clear the counter.
- START: cpu_start=1. After START_LEN cycles, go to RUN.
- RUN: cycle_cnt increments each cycle. A channel write qualifies when mon_wen=1 and waddr!=0.
  - A qualifying write with waddr==END_REG and data==PASS_VAL goes to DONE with pass=1.
  - A qualifying write with waddr==END_REG and data==FAIL_VAL goes to DONE with pass=0.
  - Any other END_REG value is ignored.
  - If cycle_cnt==MAX_CYCLES-1 with no end write, go to DONE with timeout=1 and pass=0.
- DONE: terminal. cycle_cnt is frozen. Monitoring stops. Only reset leaves DONE.
- X check (RUN only): a qualifying write whose data contains any X/Z bit does the following:
  - increments x_err_cnt, saturating at 16'hFFFF;
  - sets x_err_ch[i];
  - never matches an end code.
- Several qualifying writes in one cycle each count toward x_err_cnt, added as a population count with saturation.
- Boundary cases:
  - Multiple end writes in one cycle: the lowest channel index decides pass.
  - End write and timeout in the same cycle: the end write wins and timeout=0.
  - rst_n low in any state aborts immediately to WAIT and clears all outputs.
  - mon_wen==X is treated as an unknown write on that channel: counted, never an end.

## Timing
- All outputs are registered. Reset value of every output is 0.
- cycle numbering: cycle 0 is the first rising edge after rst_n deasserts.
- cpu_start is high on cycles START_DLY .. START_DLY+START_LEN-1.
- running rises on cycle START_DLY+START_LEN.
- An end write sampled on edge k gives done/pass on the output after edge k. Latency is 1 cycle.
- At done, cycle_cnt equals the number of RUN cycles up to and including the end-write cycle.
- Timeout: done=1 and timeout=1 appear when cycle_cnt reaches MAX_CYCLES.

## Configuration
- SIM_X_CHECK_EN defined: X/Z detection active, using a case-equality reduction on wdata and wen.
- SIM_X_CHECK_EN undefined: x_err_cnt and x_err_ch are tied to 0. No case-equality logic is elaborated. End matching uses plain equality.
- When the macro is defined, each new unknown write also issues $warning with channel, address and cycle_cnt.

## Structure
- Package sim_pkg holds:
  - the state enum (WAIT, START, RUN, DONE);
  - RF_AW=5;
  - the x_err_cnt width constant (16);
  - the saturating-add helper function.
- Sub-module sim_wr_mon, instantiated NUM_CH times, one per channel.
  - Inputs: wen, waddr, wdata, parameters END_REG, PASS_VAL, FAIL_VAL.
  - Outputs, combinational: qual, is_x, hit_pass, hit_fail.
- The top holds the FSM, counters, priority encode of hits, and popcount of is_x.

## Test plan
- Defaults, no writes.
  - Stimulus: release reset.
  - Required: cpu_start high on cycle 2 only; running from cycle 3; done=1 and timeout=1 with cycle_cnt=500000.
- Pass end code, NUM_CH=1.
  - Stimulus: write x3=1 on run cycle 100.
  - Required: next cycle done=1, pass=1, timeout=0, cycle_cnt=101, then frozen.
- Fail end code and ignored code.
  - Stimulus: x3=5 on run cycle 10, then x3=32'hDEAD_0001 on cycle 20.
  - Required: still running after cycle 10; done=1, pass=0 after cycle 20.
- NUM_CH=2 simultaneous end writes.
  - Stimulus: same cycle ch0 writes x3=FAIL_VAL, ch1 writes x3=PASS_VAL.
  - Required: pass=0.
  - Stimulus: MAX_CYCLES=50 with an end write on cycle 49.
  - Required: timeout=0.
- X check, macro defined, NUM_CH=2.
  - Stimulus: both channels write 32'hX to x5 in the same cycle; write X to x0.
  - Required: x_err_cnt=2, x_err_ch=2'b11; the x0 write is ignored.
  - Stimulus: same with macro undefined.
  - Required: x_err_cnt stays 0.
- Reset mid-run.
  - Stimulus: drop rst_n on run cycle 30.
  - Required: all outputs 0 immediately; on release, the start sequence repeats with cycle_cnt restarting from 0.

Source files
------------

// File: rtl/sim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sim_pkg
// Purpose  : Shared types, constants and helpers for the simulation run controller.
// Revision : 1.0 - initial release
// ============================================================================
package sim_pkg;

    localparam int RF_AW  = 5;
    localparam int XCNT_W = 16;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    // Adds a small per-cycle count to the unknown-write counter, clamping at all-ones.
    function automatic logic [XCNT_W-1:0] sat_add(input logic [XCNT_W-1:0] a,
                                                  input logic [3:0]        b);
        logic [XCNT_W:0] sum;
        sum = {1'b0, a} + {{(XCNT_W - 3){1'b0}}, b};
        return sum[XCNT_W] ? {XCNT_W{1'b1}} : sum[XCNT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sim_wr_mon.sv
`default_nettype none
// ============================================================================
// Module   : sim_wr_mon
// Purpose  : Combinational classifier for one register-file write port
//            (qualifying write, unknown data, pass/fail end code).
//            Unknown detection is built only when SIM_X_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sim_wr_mon
    import sim_pkg::*;
#(
    parameter int               DW       = 32,
    parameter logic [RF_AW-1:0] END_REG  = 5'd3,
    parameter logic [DW-1:0]    PASS_VAL = DW'(1),
    parameter logic [DW-1:0]    FAIL_VAL = DW'(32'hDEAD_0001)
) (
    input  logic             wen,
    input  logic [RF_AW-1:0] waddr,
    input  logic [DW-1:0]    wdata,
    output logic             qual,
    output logic             is_x,
    output logic             hit_pass,
    output logic             hit_fail
);

    logic w_end_addr;

    assign w_end_addr = (waddr == END_REG);

`ifdef SIM_X_CHECK_EN
    logic w_wen_x;
    logic w_data_x;

    // An undriven enable is treated as a write so that it gets reported.
    assign w_wen_x  = (wen === 1'bx) || (wen === 1'bz);
    assign w_data_x = ((^wdata) === 1'bx);
    assign qual     = ((wen === 1'b1) || w_wen_x) && (waddr != '0);
    assign is_x     = qual && (w_wen_x || w_data_x);
`else
    assign qual     = wen && (waddr != '0);
    assign is_x     = 1'b0;
`endif

    assign hit_pass = qual && !is_x && w_end_addr && (wdata == PASS_VAL);
    assign hit_fail = qual && !is_x && w_end_addr && (wdata == FAIL_VAL);

endmodule
`default_nettype wire

// File: rtl/sim_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sim_run_ctrl
// Purpose  : Sequences cpu_start after reset, watches NUM_CH write ports for
//            end codes / unknown data and enforces a RUN cycle budget.
//            Optional feature macro: SIM_X_CHECK_EN (unknown-write detection).
// Revision : 1.0 - initial release
// ============================================================================
module sim_run_ctrl
    import sim_pkg::*;
#(
    parameter int               DW         = 32,
    parameter int               NUM_CH     = 1,
    parameter int               START_DLY  = 2,
    parameter int               START_LEN  = 1,
    parameter int               MAX_CYCLES = 500000,
    parameter int               CW         = 32,
    parameter logic [RF_AW-1:0] END_REG    = 5'd3,
    parameter logic [DW-1:0]    PASS_VAL   = DW'(1),
    parameter logic [DW-1:0]    FAIL_VAL   = DW'(32'hDEAD_0001)
) (
    input  logic                    clkin,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       mon_wen,
    input  logic [NUM_CH*RF_AW-1:0] mon_waddr,
    input  logic [NUM_CH*DW-1:0]    mon_wdata,
    output logic                    cpu_start,
    output logic                    running,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [CW-1:0]           cycle_cnt,
    output logic [XCNT_W-1:0]       x_err_cnt,
    output logic [NUM_CH-1:0]       x_err_ch
);

    localparam int DLY_W = $clog2(START_DLY + 1) + 1;
    localparam int LEN_W = $clog2(START_LEN) + 1;

    run_state_e        r_state;
    run_state_e        w_state_nxt;
    logic [DLY_W-1:0]  r_dly;
    logic [LEN_W-1:0]  r_len;
    logic [NUM_CH-1:0] w_qual;
    logic [NUM_CH-1:0] w_is_x;
    logic [NUM_CH-1:0] w_hit_pass;
    logic [NUM_CH-1:0] w_hit_fail;
    logic              w_end_hit;
    logic              w_end_pass;
    logic              w_timeout_hit;
    logic [3:0]        w_x_pop;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mon
        sim_wr_mon #(
            .DW       (DW),
            .END_REG  (END_REG),
            .PASS_VAL (PASS_VAL),
            .FAIL_VAL (FAIL_VAL)
        ) u_mon (
            .wen      (mon_wen[gi]),
            .waddr    (mon_waddr[RF_AW*gi +: RF_AW]),
            .wdata    (mon_wdata[DW*gi +: DW]),
            .qual     (w_qual[gi]),
            .is_x     (w_is_x[gi]),
            .hit_pass (w_hit_pass[gi]),
            .hit_fail (w_hit_fail[gi])
        );
    end

    // Walk from the top channel down so the lowest index with an end code wins.
    always_comb begin
        w_end_hit  = 1'b0;
        w_end_pass = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_qual[i] && (w_hit_pass[i] || w_hit_fail[i])) begin
                w_end_hit  = 1'b1;
                w_end_pass = w_hit_pass[i];
            end
        end
    end

    always_comb begin
        w_x_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_x_pop = w_x_pop + {3'b000, w_is_x[i]};
        end
    end

    assign w_timeout_hit = (cycle_cnt == CW'(MAX_CYCLES - 1));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // WAIT is left on edge START_DLY so cpu_start is visible from cycle START_DLY.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT:  if (r_dly == DLY_W'(START_DLY))     w_state_nxt = ST_START;
            ST_START: if (r_len == LEN_W'(START_LEN - 1)) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_end_hit || w_timeout_hit)     w_state_nxt = ST_DONE;
            default:                                      w_state_nxt = ST_DONE;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_dly     <= '0;
            r_len     <= '0;
            cpu_start <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            cycle_cnt <= '0;
            x_err_cnt <= '0;
            x_err_ch  <= '0;
        end else begin
            r_dly     <= (r_state == ST_WAIT  && w_state_nxt == ST_WAIT)  ? r_dly + 1'b1 : '0;
            r_len     <= (r_state == ST_START && w_state_nxt == ST_START) ? r_len + 1'b1 : '0;
            cpu_start <= (w_state_nxt == ST_START);
            running   <= (w_state_nxt == ST_RUN);
            done      <= (w_state_nxt == ST_DONE);
            if (r_state == ST_RUN) begin
                cycle_cnt <= cycle_cnt + CW'(1);
                x_err_cnt <= sat_add(x_err_cnt, w_x_pop);
                x_err_ch  <= x_err_ch | w_is_x;
                if (w_end_hit) begin
                    pass <= w_end_pass;
                end else if (w_timeout_hit) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

`ifdef SIM_X_CHECK_EN
    always_ff @(posedge clkin) begin
        if (rst_n && r_state == ST_RUN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_is_x[i]) begin
                    $warning("sim_run_ctrl: unknown write ch%0d addr %0d cycle_cnt %0d",
                             i, mon_waddr[RF_AW*i +: RF_AW], cycle_cnt);
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sim_run_ctrl
// Purpose  : Self-checking bench for sim_run_ctrl (two channels, short budget).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sim_run_ctrl;

    localparam int          DW        = 32;
    localparam int          NUM_CH    = 2;
    localparam int          START_DLY = 2;
    localparam int          START_LEN = 1;
    localparam int          MAX_CYC   = 150;
    localparam int          CW        = 32;
    localparam logic [4:0]  END_REG   = 5'd3;
    localparam logic [31:0] PASS_VAL  = 32'd1;
    localparam logic [31:0] FAIL_VAL  = 32'hDEAD_0001;

    logic                   clkin = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_CH-1:0]      mon_wen = '0;
    logic [NUM_CH*5-1:0]    mon_waddr = '0;
    logic [NUM_CH*DW-1:0]   mon_wdata = '0;
    logic                   cpu_start, running, done, pass, timeout;
    logic [CW-1:0]          cycle_cnt;
    logic [15:0]            x_err_cnt;
    logic [NUM_CH-1:0]      x_err_ch;

    int   errors = 0;
    int   checks = 0;
    int   m_cnt;
    logic m_done, m_pass, m_to;

    always #5 clkin = ~clkin;

    sim_run_ctrl #(
        .DW (DW), .NUM_CH (NUM_CH), .START_DLY (START_DLY), .START_LEN (START_LEN),
        .MAX_CYCLES (MAX_CYC), .CW (CW), .END_REG (END_REG),
        .PASS_VAL (PASS_VAL), .FAIL_VAL (FAIL_VAL)
    ) dut (
        .clkin (clkin), .rst_n (rst_n), .mon_wen (mon_wen), .mon_waddr (mon_waddr),
        .mon_wdata (mon_wdata), .cpu_start (cpu_start), .running (running), .done (done),
        .pass (pass), .timeout (timeout), .cycle_cnt (cycle_cnt), .x_err_cnt (x_err_cnt),
        .x_err_ch (x_err_ch)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference end decision: 0 none, 1 pass, 2 fail; lowest channel decides.
    function automatic int decide(input logic [NUM_CH-1:0] wen, input logic [NUM_CH*5-1:0] ad,
                                  input logic [NUM_CH*DW-1:0] da);
        logic [4:0]  a;
        logic [31:0] d;
        for (int c = 0; c < NUM_CH; c++) begin
            a = ad[5*c +: 5];
            d = da[DW*c +: DW];
            if (wen[c] === 1'b1 && a != 5'd0 && a == END_REG && !$isunknown(d)) begin
                if (d == PASS_VAL) return 1;
                if (d == FAIL_VAL) return 2;
            end
        end
        return 0;
    endfunction

    task automatic step(input logic [NUM_CH-1:0] wen, input logic [NUM_CH*5-1:0] ad,
                        input logic [NUM_CH*DW-1:0] da, input string tag);
        int res;
        mon_wen   = wen;
        mon_waddr = ad;
        mon_wdata = da;
        res = decide(wen, ad, da);
        @(posedge clkin);
        #1;
        if (!m_done) begin
            m_cnt++;
            if (res != 0) begin
                m_done = 1'b1;
                m_pass = (res == 1);
            end else if (m_cnt == MAX_CYC) begin
                m_done = 1'b1;
                m_to   = 1'b1;
            end
        end
        check({tag, " done"},      done,      m_done);
        check({tag, " pass"},      pass,      m_pass);
        check({tag, " timeout"},   timeout,   m_to);
        check({tag, " running"},   running,   !m_done);
        check({tag, " cycle_cnt"}, cycle_cnt, m_cnt);
        check({tag, " cpu_start"}, cpu_start, 1'b0);
        mon_wen = '0;
    endtask

    // Random distractors: data always has bit 8 set, so it never equals an end code.
    task automatic rand_step();
        logic [NUM_CH-1:0]    wen;
        logic [NUM_CH*5-1:0]  ad;
        logic [NUM_CH*DW-1:0] da;
        for (int c = 0; c < NUM_CH; c++) begin
            wen[c]        = 1'($urandom_range(0, 1));
            ad[5*c +: 5]  = ($urandom_range(0, 3) == 0) ? END_REG : 5'($urandom_range(0, 31));
            da[DW*c +: DW] = $urandom | 32'h100;
        end
        step(wen, ad, da, "rnd");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl"},      {cpu_start, running, done, pass, timeout}, 5'b0);
        check({tag, " cycle_cnt"}, cycle_cnt, 0);
        check({tag, " x_err_cnt"}, x_err_cnt, 0);
        check({tag, " x_err_ch"},  x_err_ch,  0);
    endtask

    task automatic start_seq();
        rst_n     = 1'b0;
        mon_wen   = '0;
        mon_waddr = '0;
        mon_wdata = '0;
        repeat (2) @(posedge clkin);
        #1;
        check_all_zero("reset");
        @(negedge clkin);
        rst_n = 1'b1;
        for (int k = 0; k <= START_DLY + START_LEN; k++) begin
            @(posedge clkin);
            #1;
            check($sformatf("start c%0d cpu_start", k), cpu_start,
                  (k >= START_DLY && k < START_DLY + START_LEN));
            check($sformatf("start c%0d running", k), running, (k >= START_DLY + START_LEN));
        end
        m_cnt  = 0;
        m_done = 1'b0;
        m_pass = 1'b0;
        m_to   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_CH*DW-1:0] xd;
        xd = 'x;

        // Pass code on run cycle 100, then frozen.
        start_seq();
        repeat (100) rand_step();
        step(2'b01, {5'd0, END_REG}, {32'd0, PASS_VAL}, "pass end");
        check("pass cnt101", cycle_cnt, 101);
        check("pass flag", pass, 1'b1);
        repeat (5) rand_step();
        check("pass frozen", cycle_cnt, 101);

        // Ignored code on cycle 10, fail code on cycle 20.
        start_seq();
        repeat (10) rand_step();
        step(2'b01, {5'd0, END_REG}, {32'd0, 32'd5}, "ignored");
        check("ignored running", running, 1'b1);
        repeat (9) rand_step();
        step(2'b01, {5'd0, END_REG}, {32'd0, FAIL_VAL}, "fail end");
        check("fail done", {done, pass}, 2'b10);
        check("fail cnt21", cycle_cnt, 21);

        // Simultaneous end writes: lowest channel decides.
        start_seq();
        repeat (5) rand_step();
        step(2'b11, {END_REG, END_REG}, {PASS_VAL, FAIL_VAL}, "ch0 fail ch1 pass");
        check("simul pass0", {done, pass}, 2'b10);
        start_seq();
        step(2'b11, {END_REG, END_REG}, {FAIL_VAL, PASS_VAL}, "ch0 pass ch1 fail");
        check("simul pass1", {done, pass}, 2'b11);
        start_seq();
        step(2'b11, {END_REG, 5'd0}, {FAIL_VAL, PASS_VAL}, "x0 ignored");
        check("x0 ignored fail", {done, pass}, 2'b10);

        // Timeout with no end write.
        start_seq();
        repeat (MAX_CYC) rand_step();
        check("timeout flags", {done, pass, timeout}, 3'b101);
        check("timeout cnt", cycle_cnt, MAX_CYC);

        // End write on the last budget cycle beats timeout.
        start_seq();
        repeat (MAX_CYC - 1) rand_step();
        step(2'b10, {END_REG, 5'd0}, {PASS_VAL, 32'd0}, "end at budget");
        check("end beats timeout", {done, pass, timeout}, 3'b110);
        check("end beats cnt", cycle_cnt, MAX_CYC);

        // Unknown data on two channels, then unknown data to x0.
        start_seq();
        step(2'b11, {5'd5, 5'd5}, xd, "x both");
        step(2'b01, {5'd0, 5'd0}, xd, "x to x0");
`ifdef SIM_X_CHECK_EN
        check("x_err_cnt", x_err_cnt, 2);
        check("x_err_ch", x_err_ch, 2'b11);
`else
        check("x_err_cnt off", x_err_cnt, 0);
        check("x_err_ch off", x_err_ch, 0);
`endif

        // Reset mid-run on run cycle 30.
        start_seq();
        repeat (30) rand_step();
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun reset");
        start_seq();
        rand_step();
        check("restart cnt", cycle_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
